// File: rtl/fence_pkg.sv
// Shared widths, defaults and helpers for the geofence result collector.
package fence_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int IDXW_DEF  = 8;
  localparam int CNTW      = 8;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Record layout is {index, is_inside}.
  function automatic int rec_w(input int idxw);
    return idxw + 1;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNTW'(1);
  endfunction

endpackage

// File: rtl/fence_fifo.sv
// Result FIFO: single-clock, power-of-two depth, head read combinationally.
// Push accepted when not full or when popping on the same edge; pop on empty is ignored.
module fence_fifo
  import fence_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = rec_w(IDXW_DEF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          do_push;
  logic          do_pop;

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_FULL);
  assign do_pop  = pop & ~empty;
  // When full, the slot freed by a same-edge pop is the one being written.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fence_collect.sv
// Collects geofence verdict strobes into indexed records with running totals; records appear 1 cycle after the strobe.
// Host backpressure via out_valid/out_ready; a strobe arriving while the queue is full with no pop is dropped and flagged.
module fence_collect
  import fence_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic            is_inside,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_index,
  output logic            out_inside,
  output logic [CNTW-1:0] inside_cnt,
  output logic [CNTW-1:0] outside_cnt,
  output logic            overflow,
  output logic            proto_err
);

  localparam int RW = rec_w(IDXW);
  localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

  logic            prev_valid;
  logic            accept;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IDXW-1:0] obj_idx;
  logic [RW-1:0]   head;

  assign accept = valid & ~prev_valid;
  assign pop    = out_valid & out_ready;

  fence_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_dat ({obj_idx, is_inside}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign out_valid  = ~fifo_empty;
  // Gate the head so the record outputs read zero whenever nothing is queued.
  assign out_index  = out_valid ? head[RW-1:1] : '0;
  assign out_inside = out_valid & head[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_valid  <= 1'b0;
      proto_err   <= 1'b0;
      overflow    <= 1'b0;
      obj_idx     <= '0;
      inside_cnt  <= '0;
      outside_cnt <= '0;
    end else begin
      prev_valid <= valid;
      if (valid & prev_valid) proto_err <= 1'b1;
      if (accept) begin
        obj_idx <= obj_idx + IDX_ONE;
        if (is_inside) inside_cnt  <= sat_inc(inside_cnt);
        else           outside_cnt <= sat_inc(outside_cnt);
        if (fifo_full & ~pop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fence_collect.sv
// Directed and random stimulus for fence_collect against a queue-based reference model.
module tb_fence_collect;

  localparam int DEPTH = 8;
  localparam int IDXW  = 8;

  logic            clk;
  logic            reset;
  logic            valid;
  logic            is_inside;
  logic            out_valid;
  logic            out_ready;
  logic [IDXW-1:0] out_index;
  logic            out_inside;
  logic [7:0]      inside_cnt;
  logic [7:0]      outside_cnt;
  logic            overflow;
  logic            proto_err;

  fence_collect #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid),
    .is_inside   (is_inside),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_inside  (out_inside),
    .inside_cnt  (inside_cnt),
    .outside_cnt (outside_cnt),
    .overflow    (overflow),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: each record stored as index*2 + verdict.
  int q[$];
  int m_idx, m_in, m_out;
  bit m_ovf, m_perr, m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = 0; m_in = 0; m_out = 0;
    m_ovf = 0; m_perr = 0; m_prev = 0;
  endtask

  task automatic model_edge(input bit v, input bit ins, input bit rdy);
    bit acc;
    acc = v && !m_prev;
    if (v && m_prev) m_perr = 1;
    m_prev = v;
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      if (q.size() < DEPTH) q.push_back(m_idx * 2 + int'(ins));
      else m_ovf = 1;
      m_idx = (m_idx + 1) % (1 << IDXW);
      if (ins) begin if (m_in < 255) m_in++; end
      else begin if (m_out < 255) m_out++; end
    end
  endtask

  task automatic check_all();
    chk("out_valid",   32'(out_valid),   32'(q.size() != 0));
    chk("out_index",   32'(out_index),   (q.size() != 0) ? q[0] / 2 : 0);
    chk("out_inside",  32'(out_inside),  (q.size() != 0) ? q[0] % 2 : 0);
    chk("inside_cnt",  32'(inside_cnt),  m_in);
    chk("outside_cnt", 32'(outside_cnt), m_out);
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("proto_err",   32'(proto_err),   32'(m_perr));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input bit v, input bit ins, input bit rdy);
    valid = v; is_inside = ins; out_ready = rdy;
    @(posedge clk);
    model_edge(v, ins, rdy);
    @(negedge clk);
    check_all();
  endtask

  task automatic strobe(input bit ins, input bit rdy);
    step(1'b1, ins, rdy);
    step(1'b0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    valid = 0; is_inside = 0; out_ready = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  int n;

  initial begin
    reset = 0; valid = 0; is_inside = 0; out_ready = 0;
    model_reset();
    #1;
    reset = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Three strobes with host ready: each record visible one cycle after its strobe.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'(k != 1), 1'b1);
      chk("s3_vld", 32'(out_valid), 1);
      chk("s3_idx", 32'(out_index), k);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("s3_in_cnt", 32'(inside_cnt), 2);
    chk("s3_out_cnt", 32'(outside_cnt), 1);

    // Nine strobes into a stalled host: one dropped, drain yields 0..7, next gets 9.
    do_reset();
    for (int k = 0; k < 9; k++) strobe(1'($urandom_range(0, 1)), 1'b0);
    chk("ovf_set", 32'(overflow), 1);
    for (int k = 0; k < 8; k++) begin
      chk("drain_idx", 32'(out_index), k);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("drained", 32'(out_valid), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("after_drop_idx", 32'(out_index), 9);
    step(1'b0, 1'b0, 1'b1);

    // Full queue with a pop and a push on the same edge.
    do_reset();
    for (int k = 0; k < 8; k++) strobe(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("full_pp_ovf", 32'(overflow), 0);
    step(1'b0, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) n++;
      step(1'b0, 1'b0, 1'b1);
    end
    chk("full_pp_occ", n, 8);

    // Valid held for three cycles.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("perr_set", 32'(proto_err), 1);
    chk("perr_in_cnt", 32'(inside_cnt), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("perr_one_rec", 32'(out_valid), 0);

    // Counter saturation and index wrap.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (k >= 254 && k <= 257) chk("wrap_idx", 32'(out_index), k % 256);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("sat_in_cnt", 32'(inside_cnt), 255);
    chk("sat_out_cnt", 32'(outside_cnt), 0);

    // Asynchronous reset with records queued.
    do_reset();
    for (int k = 0; k < 4; k++) strobe(1'b1, 1'b0);
    chk("pre_rst_vld", 32'(out_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", 32'(out_valid), 0);
    chk("async_rst_idx", 32'(out_index), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_all();
    chk("rst_in_cnt", 32'(inside_cnt), 0);
    chk("rst_out_cnt", 32'(outside_cnt), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_first_idx", 32'(out_index), 0);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic, alternating between mostly-ready and mostly-stalled host.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      if ((i / 100) % 2 == 1) rdy = 1'($urandom_range(0, 3) == 0);
      else                    rdy = 1'($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fence_collect.md
FENCE_COLLECT -- requirements
Module: fence_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning result FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter IDXW, default 8, meaning object index width.
REQ-003 SHALL have port clk, input, 1, meaning single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port valid, input, 1, meaning one-cycle result strobe from the geofence stage.
REQ-006 SHALL have port is_inside, input, 1, meaning the verdict qualified by valid.
REQ-007 SHALL have port out_valid, output, 1, meaning the head record is available.
REQ-008 SHALL have port out_ready, input, 1, meaning the host accepts the head record.
REQ-009 SHALL have port out_index, output, IDXW, meaning the object number of the head record.
REQ-010 SHALL have port out_inside, output, 1, meaning the verdict of the head record.
REQ-011 SHALL have ports inside_cnt and outside_cnt, output, 8 each, meaning running totals.
REQ-012 SHALL have port overflow, output, 1, meaning sticky flag: a result was dropped.
REQ-013 SHALL have port proto_err, output, 1, meaning sticky flag: valid was held high for more than 1 cycle.

Function
REQ-014 SHALL treat a result as accepted on a clock edge where valid=1 and valid was 0 on the previous edge (rising-edge strobe).
REQ-015 SHALL set proto_err on any edge where valid=1 and the registered previous valid=1; the extra cycles SHALL NOT create records.
REQ-016 SHALL keep an IDXW-bit object counter, starting at 0, that increments on every accepted result (dropped or not) and wraps from 2^IDXW-1 to 0.
REQ-017 SHALL form each record as {index, is_inside} and push it into the FIFO on the accepting edge.
REQ-018 SHALL raise out_valid on the edge following the push into an empty FIFO, giving 1-cycle latency.
REQ-019 SHALL drive out_valid as "FIFO not empty", with out_index and out_inside taken from the head entry.
REQ-020 SHALL pop the head entry on an edge where out_valid=1 and out_ready=1.
REQ-021 SHALL keep out_index and out_inside stable while out_valid=1 and out_ready=0.
REQ-022 SHALL accept a push when the FIFO is full and a pop occurs on the same edge; the occupancy is unchanged.
REQ-023 SHALL drop a push when the FIFO is full and no pop occurs, and SHALL set overflow; the counters and index still advance.
REQ-024 SHALL perform a simultaneous push and pop on a non-empty, non-full FIFO with unchanged occupancy.
REQ-025 SHALL ignore a pop on an empty FIFO.
REQ-026 SHALL increment inside_cnt when is_inside=1 on each accepted result, and outside_cnt otherwise.
REQ-027 SHALL saturate both counters at 255.
REQ-028 SHALL wrap the FIFO pointers modulo DEPTH, with full/empty taken from a (log2(DEPTH)+1)-bit occupancy count.
REQ-029 SHALL ignore is_inside whenever valid=0.

Reset
REQ-030 SHALL, on reset assertion and asynchronously, clear out_valid, overflow, proto_err, inside_cnt, outside_cnt, the object counter, the pointers, the occupancy count and the previous-valid register.
REQ-031 SHALL drive out_index and out_inside to 0 during reset.
REQ-032 SHALL, on reset mid-operation, discard all queued records; the first accepted result after release SHALL carry index 0.

Structure
REQ-033 SHALL define DEPTH/IDXW defaults, the record width (IDXW+1) and the counter width in the shared package fence_pkg.
REQ-034 SHALL place the FIFO storage, pointers and occupancy logic in the sub-module fence_fifo (push/pop/full/empty/head).
REQ-035 SHALL keep edge detection, the counters, the sticky flags and the index generation in fence_collect.

Verification
REQ-036 SHALL cover: three single-cycle strobes (inside=1,0,1) with out_ready=1 -> records idx 0,1,2 each appear 1 cycle after their strobe; inside_cnt=2, outside_cnt=1.
REQ-037 SHALL cover: out_ready=0 and 9 strobes with DEPTH=8 -> 8 records held, overflow=1; then draining returns idx 0..7; the next strobe gets idx 9.
REQ-038 SHALL cover: FIFO full with out_ready=1 and a strobe on the same edge -> push accepted, overflow stays 0, occupancy stays 8.
REQ-039 SHALL cover: valid held high for 3 cycles -> exactly one record, proto_err=1.
REQ-040 SHALL cover: 300 inside strobes -> inside_cnt=255 saturated; out_index wraps 255->0.
REQ-041 SHALL cover: reset asserted while 4 records are queued -> out_valid=0 immediately; after release the next record is idx 0 and both counters read 0.
